// File: rtl/range_seq_arbiter.sv
// range_seq_arbiter
//   Shares one range-finder datapath between NUM_REQ sample streams. An
//   idle controller grants the first pending requester at or after a
//   round-robin pointer. It then turns that requester's valid/last stream
//   into the datapath's go/finish/data beats. On the cycle after the
//   finish beat it returns the datapath's range together with the
//   requester id and an error flag.
//
//   Optional feature: define RANGE_SEQ_ARBITER_TIMEOUT_EN to abandon a
//   stalled sequence after TIMEOUT consecutive idle cycles.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req[NUM_REQ]          per-requester "sequence pending"
//   s_valid/s_last        per-requester sample valid / final sample
//   s_data                packed samples, requester i at [i*WIDTH +: WIDTH]
//   s_ready[NUM_REQ]      sample accepted on s_valid & s_ready
//   grant[NUM_REQ]        one-hot datapath owner
//   rf_go/rf_finish       datapath go / finish beats (never both at once)
//   rf_data               datapath data_in
//   rf_range, rf_error    datapath range (valid in finish cycle) and error
//   res_valid             one-cycle result strobe
//   res_data/res_id/res_err  captured range, requester index, invalid flag
//   busy                  a grant is held
module range_seq_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         s_valid,
    input  logic [NUM_REQ-1:0]         s_last,
    input  logic [NUM_REQ*WIDTH-1:0]   s_data,
    output logic [NUM_REQ-1:0]         s_ready,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       rf_go,
    output logic                       rf_finish,
    output logic [WIDTH-1:0]           rf_data,
    input  logic [WIDTH-1:0]           rf_range,
    input  logic                       rf_error,
    output logic                       res_valid,
    output logic [WIDTH-1:0]           res_data,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic                       res_err,
    output logic                       busy
);
    localparam int           IDW  = $clog2(NUM_REQ);
    localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("range_seq_arbiter: NUM_REQ must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("range_seq_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, START, STREAM, CLOSE} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic             err_q, err_d;
    logic             cap;      // finish beat this cycle, capture next edge
    logic             abort;    // START timed out, report an empty result
    logic             hs;

`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Unpacked view of the samples so the owner's sample is a plain index.
    logic [WIDTH-1:0] samp [NUM_REQ];
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_samp
        assign samp[i] = s_data[i*WIDTH +: WIDTH];
    end

    // (a + b) mod NUM_REQ for a, b < NUM_REQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                                input logic [IDW-1:0] b);
        logic [IDW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    // Round-robin pick: rotate req so the pointer sits at bit 0, then take
    // the lowest set bit as an offset from the pointer.
    logic [NUM_REQ-1:0] req_rot;
    logic [IDW-1:0]     pick_off;
    logic               pick_vld;

    always_comb begin
        req_rot  = NUM_REQ'({req, req} >> ptr_q);
        pick_vld = |req_rot;
        pick_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) pick_off = k[IDW-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        gid_d     = gid_q;
        ptr_d     = ptr_q;
        held_d    = held_q;
        err_d     = err_q;
        s_ready   = '0;
        rf_go     = 1'b0;
        rf_finish = 1'b0;
        rf_data   = '0;
        cap       = 1'b0;
        abort     = 1'b0;
        hs        = s_valid[gid_q];
`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = START;
                    gid_d   = wrap_add(ptr_q, pick_off);
                    ptr_d   = wrap_add(gid_d, IDW'(1));
                    err_d   = 1'b0;
`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            START: begin
                s_ready[gid_q] = 1'b1;
                if (rf_error) err_d = 1'b1;
                if (hs) begin
                    rf_go   = 1'b1;
                    rf_data = samp[gid_q];
                    held_d  = samp[gid_q];
                    // A single-sample sequence needs a separate finish beat.
                    state_d = s_last[gid_q] ? CLOSE : STREAM;
`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                        abort   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            STREAM: begin
                s_ready[gid_q] = 1'b1;
                if (rf_error) err_d = 1'b1;
                if (hs) begin
                    rf_data = samp[gid_q];
`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (s_last[gid_q]) begin
                        rf_finish = 1'b1;
                        cap       = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        held_d = samp[gid_q];
                    end
                end else begin
                    // Re-drive a value the datapath has already seen so
                    // its min/max stay put while the source stalls.
                    rf_data = held_q;
`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = CLOSE;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            CLOSE: begin
                if (rf_error) err_d = 1'b1;
                rf_finish = 1'b1;
                rf_data   = held_q;
                cap       = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            gid_q     <= '0;
            ptr_q     <= '0;
            held_q    <= '0;
            err_q     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gid_q     <= gid_d;
            ptr_q     <= ptr_d;
            held_q    <= held_d;
            err_q     <= err_d;
            res_valid <= cap | abort;
            if (cap | abort) begin
                res_data <= abort ? '0 : rf_range;
                res_id   <= gid_q;
                res_err  <= abort | err_q | rf_error;
            end
`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);

    always_comb begin
        grant = '0;
        if (busy) grant[gid_q] = 1'b1;
    end

endmodule

// File: tb/tb_range_seq_arbiter.sv
module tb_range_seq_arbiter;
    localparam int W  = 8;
    localparam int NR = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bit         req_r  [NR];
    bit         val_r  [NR];
    bit         last_r [NR];
    logic [W-1:0] dat_r [NR];

    logic [NR-1:0]   req, s_valid, s_last, s_ready, grant;
    logic [NR*W-1:0] s_data;
    logic            rf_go, rf_finish, rf_error, res_valid, res_err, busy;
    logic [W-1:0]    rf_data, rf_range, res_data;
    logic [1:0]      res_id;

    always_comb begin
        req = '0; s_valid = '0; s_last = '0; s_data = '0;
        for (int i = 0; i < NR; i++) begin
            req[i]          = req_r[i];
            s_valid[i]      = val_r[i];
            s_last[i]       = last_r[i];
            s_data[i*W +: W] = dat_r[i];
        end
    end

    range_seq_arbiter #(.WIDTH(W), .NUM_REQ(NR), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .req(req), .s_valid(s_valid),
        .s_last(s_last), .s_data(s_data), .s_ready(s_ready), .grant(grant),
        .rf_go(rf_go), .rf_finish(rf_finish), .rf_data(rf_data),
        .rf_range(rf_range), .rf_error(rf_error), .res_valid(res_valid),
        .res_data(res_data), .res_id(res_id), .res_err(res_err), .busy(busy)
    );

    // Behavioural range finder: go loads min/max, data cycles update them,
    // finish presents max-min including the finish sample combinationally.
    logic         act;
    logic [W-1:0] mn, mx, lo, hi;
    always_comb begin
        lo = (rf_data < mn) ? rf_data : mn;
        hi = (rf_data > mx) ? rf_data : mx;
        rf_range = rf_finish ? (hi - lo) : '0;
    end
    always @(posedge clock) begin
        if (reset) begin
            act <= 1'b0; mn <= '0; mx <= '0;
        end else if (rf_go) begin
            act <= 1'b1; mn <= rf_data; mx <= rf_data;
        end else if (rf_finish) begin
            act <= 1'b0;
        end else if (act) begin
            mn <= lo; mx <= hi;
        end
    end

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   id;
        logic         e;
    } exp_t;
    exp_t q[$];
    exp_t em;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input int act_v, input int exp_v);
        vecs++;
        if (act_v !== exp_v) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (!reset && res_valid) begin
            if (q.size() == 0) begin
                vecs++; errs++;
                $display("FAIL unexpected_result: got id %0d data %0d, expected no result",
                         res_id, res_data);
            end else begin
                em = q.pop_front();
                chk("res_data", int'(res_data), int'(em.d));
                chk("res_id",   int'(res_id),   int'(em.id));
                chk("res_err",  int'(res_err),  int'(em.e));
            end
        end
        if (!reset && (rf_go || rf_finish))
            chk("go_finish_exclusive", int'(rf_go & rf_finish), 0);
    end

    // Present one sample, wait (bounded) for the handshake, report the
    // datapath beat seen in the handshake cycle.
    task automatic send(input int id, input logic [W-1:0] d, input bit last,
                        output logic go, output logic fin, output logic [W-1:0] dat);
        int n = 0;
        @(negedge clock);
        val_r[id] = 1'b1; dat_r[id] = d; last_r[id] = last;
        #1;
        while (!s_ready[id] && n < 200) begin
            @(negedge clock); #1; n++;
        end
        if (n >= 200) chk("handshake_wait", 1, 0);
        go = rf_go; fin = rf_finish; dat = rf_data;
        @(posedge clock); #1;
        val_r[id] = 1'b0; last_r[id] = 1'b0; dat_r[id] = '0;
        if (last) req_r[id] = 1'b0;
    endtask

    logic g, f;
    logic [W-1:0] dd;

    initial begin
        rf_error = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_r[i] = 0; val_r[i] = 0; last_r[i] = 0; dat_r[i] = '0;
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_grant", int'(grant), 0);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_rf_go", int'(rf_go), 0);
        chk("rst_rf_finish", int'(rf_finish), 0);
        chk("rst_rf_data", int'(rf_data), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_res_err", int'(res_err), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;

        // Requester 0: 5, 9, 2(last) -> range 7.
        req_r[0] = 1;
        q.push_back('{d: 8'd7, id: 2'd0, e: 1'b0});
        send(0, 8'd5, 0, g, f, dd);
        chk("t1_go", int'(g), 1); chk("t1_go_data", int'(dd), 5);
        send(0, 8'd9, 0, g, f, dd);
        chk("t1_mid_go", int'(g), 0); chk("t1_mid_data", int'(dd), 9);
        send(0, 8'd2, 1, g, f, dd);
        chk("t1_fin", int'(f), 1); chk("t1_fin_data", int'(dd), 2);

        // Requester 1: single sample 42 -> go beat then CLOSE finish beat.
        req_r[1] = 1;
        q.push_back('{d: 8'd0, id: 2'd1, e: 1'b0});
        send(1, 8'd42, 1, g, f, dd);
        chk("t2_go", int'(g), 1); chk("t2_go_fin", int'(f), 0);
        chk("t2_go_data", int'(dd), 42);
        @(negedge clock);
        chk("t2_close_fin", int'(rf_finish), 1);
        chk("t2_close_data", int'(rf_data), 42);
        chk("t2_close_ready", int'(s_ready), 0);

        // Requester 2: rf_error pulse mid-stream is reported, not fatal.
        req_r[2] = 1;
        q.push_back('{d: 8'd5, id: 2'd2, e: 1'b1});
        send(2, 8'd3, 0, g, f, dd);
        @(negedge clock); rf_error = 1'b1;
        @(negedge clock); rf_error = 1'b0;
        chk("t3_grant_kept", int'(grant), 4);
        send(2, 8'd8, 1, g, f, dd);
        chk("t3_fin", int'(f), 1);

        // Requester 3: 10, 3 stall cycles, 30(last) -> range 20.
        req_r[3] = 1;
        q.push_back('{d: 8'd20, id: 2'd3, e: 1'b0});
        send(3, 8'd10, 0, g, f, dd);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t4_stall_data", int'(rf_data), 10);
            chk("t4_stall_go", int'(rf_go), 0);
            chk("t4_stall_fin", int'(rf_finish), 0);
        end
        send(3, 8'd30, 1, g, f, dd);

        // Reset mid-stream abandons the sequence.
        req_r[1] = 1;
        send(1, 8'd11, 0, g, f, dd);
        @(negedge clock);
        reset = 1'b1; req_r[1] = 0;
        @(negedge clock);
        reset = 1'b0;
        chk("t5_grant", int'(grant), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_rf_go", int'(rf_go), 0);
        chk("t5_rf_fin", int'(rf_finish), 0);
        chk("t5_rf_data", int'(rf_data), 0);
        repeat (4) @(negedge clock);

        // Round robin from pointer 0: 0, 2, then 0, 1 after wrap.
        q.push_back('{d: 8'd3, id: 2'd0, e: 1'b0});
        q.push_back('{d: 8'd0, id: 2'd2, e: 1'b0});
        req_r[0] = 1; req_r[2] = 1;
        fork
            begin
                logic g0, f0; logic [W-1:0] d0;
                send(0, 8'd1, 0, g0, f0, d0);
                send(0, 8'd4, 1, g0, f0, d0);
            end
            begin
                logic g2, f2; logic [W-1:0] d2;
                send(2, 8'd6, 1, g2, f2, d2);
            end
        join
        @(negedge clock);
        q.push_back('{d: 8'd5, id: 2'd0, e: 1'b0});
        q.push_back('{d: 8'd10, id: 2'd1, e: 1'b0});
        req_r[0] = 1; req_r[1] = 1;
        fork
            begin
                logic g0, f0; logic [W-1:0] d0;
                send(0, 8'd20, 0, g0, f0, d0);
                send(0, 8'd25, 1, g0, f0, d0);
            end
            begin
                logic g1, f1; logic [W-1:0] d1;
                send(1, 8'd100, 0, g1, f1, d1);
                send(1, 8'd90, 1, g1, f1, d1);
            end
        join

`ifdef RANGE_SEQ_ARBITER_TIMEOUT_EN
        // TIMEOUT=4: sample 7 then silence forces a CLOSE with error.
        req_r[0] = 1;
        q.push_back('{d: 8'd0, id: 2'd0, e: 1'b1});
        send(0, 8'd7, 0, g, f, dd);
        req_r[0] = 0;
        begin
            int n = 0;
            @(negedge clock);
            while (!rf_finish && n < 20) begin @(negedge clock); n++; end
            chk("t7_close_seen", int'(rf_finish), 1);
            chk("t7_close_data", int'(rf_data), 7);
        end
`else
        // No timeout: the grant is held through a long stall.
        req_r[1] = 1;
        q.push_back('{d: 8'd0, id: 2'd1, e: 1'b0});
        send(1, 8'd7, 0, g, f, dd);
        req_r[1] = 0;
        repeat (50) @(negedge clock);
        chk("t7_grant_held", int'(grant), 2);
        chk("t7_busy_held", int'(busy), 1);
        send(1, 8'd7, 1, g, f, dd);
        chk("t7_fin", int'(f), 1);
`endif

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
